// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   owner_t : owner of an in-flight synchronous read
//   AW_DEF / DW_DEF : default address / data widths
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating starvation counter for the DMA port.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous, active-low reset (count -> 0)
//   inc    : count one more denied cycle (saturates at MAX_WAIT)
//   clr    : clear the count (wins over inc)
//   at_max : count has reached MAX_WAIT
module dmem_arb_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  assign at_max = (cnt == CW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage (CPU port) and a
// debug/DMA master. CPU has priority; after MAX_WAIT consecutive denied DMA
// cycles the DMA port is granted once and the CPU stalls. Read data returns
// one cycle after grant; the rvalid flags mark which port owns it.
// Ports:
//   clk, rst                       : clock / synchronous active-low reset
//   cpu_req/we/addr/wdata          : CPU access request
//   cpu_stall                      : CPU request not serviced this cycle
//   cpu_rdata/cpu_rvalid           : CPU load data and its valid flag
//   dma_req/we/addr/wdata          : DMA access request
//   dma_gnt                        : DMA request accepted this cycle
//   dma_rdata/dma_rvalid           : DMA read data and its valid flag
//   mem_we/addr/wdata, mem_rdata   : single-port synchronous-read memory
// Optional (macro DMEM_ARB_PERF_EN):
//   cpu_stall_cycles [31:0]        : stalled CPU cycles, wrapping
//   dma_forced_cnt   [15:0]        : forced DMA grants, saturating
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   cpu_stall_cycles,
  output logic [15:0]   dma_forced_cnt
`endif
);

  logic   at_max;
  logic   force_dma;
  logic   cpu_granted;
  logic   dma_granted;
  owner_t rd_owner;

  dmem_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc   (dma_req & ~dma_granted),
    .clr   (~dma_req | dma_granted),
    .at_max(at_max)
  );

  // Grants are suppressed entirely while reset is held.
  assign force_dma   = rst & dma_req & at_max;
  assign cpu_granted = rst & ~force_dma & cpu_req;
  assign dma_granted = force_dma | (rst & ~cpu_req & dma_req);

  assign cpu_stall = rst & cpu_req & ~cpu_granted;
  assign dma_gnt   = dma_granted;

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_granted & cpu_we;
    if (dma_granted) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_owner <= OWN_NONE;
    end else if (cpu_granted && !cpu_we) begin
      rd_owner <= OWN_CPU;
    end else if (dma_granted && !dma_we) begin
      rd_owner <= OWN_DMA;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  // rvalid is also masked by rst so a read granted just before reset
  // asserts never delivers a response.
  assign cpu_rvalid = rst & (rd_owner == OWN_CPU);
  assign dma_rvalid = rst & (rd_owner == OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_stall_cycles <= '0;
      dma_forced_cnt   <= '0;
    end else begin
      if (cpu_stall) begin
        cpu_stall_cycles <= cpu_stall_cycles + 1'b1;
      end
      if (force_dma && (dma_forced_cnt != '1)) begin
        dma_forced_cnt <= dma_forced_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] cpu_stall_cycles;
  logic [15:0] dma_forced_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW(32),
    .DW(32),
    .MAX_WAIT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_rdata (dma_rdata),
    .dma_rvalid(dma_rvalid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .cpu_stall_cycles(cpu_stall_cycles),
    .dma_forced_cnt  (dma_forced_cnt)
`endif
  );

  // Synchronous-read, single-port word memory behind the arbiter.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Checks happen mid-cycle, away from the active edge.
  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h2;

    // Reset held 4 cycles with both ports requesting writes.
    repeat (4) @(posedge clk);
    sample();
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
`ifdef DMEM_ARB_PERF_EN
    chk("rst_stall_cycles", cpu_stall_cycles, 32'd0);
    chk("rst_forced_cnt", {16'd0, dma_forced_cnt}, 32'd0);
`endif

    // Release: both request reads, CPU wins.
    next_cycle();
    rst = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
    sample();
    chk("rel_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rel_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("rel_mem_addr", mem_addr, 32'h10);
    chk("rel_mem_we", {31'd0, mem_we}, 32'd0);

    // CPU store 0xDEADBEEF to 0x40; read from release cycle returns now.
    next_cycle();
    cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF; dma_req = 1'b0;
    sample();
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_addr", mem_addr, 32'h40);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("st_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);

    // CPU load 0x40.
    next_cycle();
    cpu_we = 1'b0;
    sample();
    chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
    chk("ld_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("ld_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);

    // Load data one cycle after grant; idle cycle keeps CPU address on mem.
    next_cycle();
    cpu_req = 1'b0; cpu_addr = 32'h44;
    sample();
    chk("ld_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("ld_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    chk("idle_mem_addr", mem_addr, 32'h44);
    chk("idle_mem_we", {31'd0, mem_we}, 32'd0);

    // DMA only: write then read 0x80.
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h12345678;
    sample();
    chk("dw_dma_gnt", {31'd0, dma_gnt}, 32'd1);
    chk("dw_mem_we", {31'd0, mem_we}, 32'd1);
    chk("dw_mem_addr", mem_addr, 32'h80);
    chk("dw_mem_wdata", mem_wdata, 32'h12345678);

    next_cycle();
    dma_we = 1'b0;
    sample();
    chk("dr_dma_gnt", {31'd0, dma_gnt}, 32'd1);
    chk("dr_mem_we", {31'd0, mem_we}, 32'd0);
    chk("dr_cpu_stall", {31'd0, cpu_stall}, 32'd0);

    next_cycle();
    dma_req = 1'b0;
    sample();
    chk("dr_rvalid", {31'd0, dma_rvalid}, 32'd1);
    chk("dr_rdata", dma_rdata, 32'h12345678);
    chk("dr_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);

    // Starvation: both read continuously; every 5th cycle goes to DMA.
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
      sample();
      chk($sformatf("sv_dma_gnt_%0d", k), {31'd0, dma_gnt}, {31'd0, (k % 5) == 4});
      chk($sformatf("sv_cpu_stall_%0d", k), {31'd0, cpu_stall}, {31'd0, (k % 5) == 4});
      chk($sformatf("sv_mem_addr_%0d", k), mem_addr, ((k % 5) == 4) ? 32'h80 : 32'h40);
      if (k > 0) begin
        chk($sformatf("sv_cpu_rvalid_%0d", k), {31'd0, cpu_rvalid}, {31'd0, ((k - 1) % 5) != 4});
        chk($sformatf("sv_dma_rvalid_%0d", k), {31'd0, dma_rvalid}, {31'd0, ((k - 1) % 5) == 4});
        chk($sformatf("sv_rdata_%0d", k), cpu_rdata,
            (((k - 1) % 5) == 4) ? 32'h12345678 : 32'hDEADBEEF);
      end
    end

    next_cycle();
    cpu_req = 1'b0; dma_req = 1'b0;
    sample();
    chk("sv_tail_dma_rvalid", {31'd0, dma_rvalid}, 32'd1);
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall_cycles", cpu_stall_cycles, 32'd4);
    chk("perf_forced_cnt", {16'd0, dma_forced_cnt}, 32'd4);
`endif

    // Reset mid-read: CPU load granted, reset asserted before data returns.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    sample();
    chk("mr_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("mr_mem_addr", mem_addr, 32'h40);

    next_cycle();
    rst = 1'b0; cpu_req = 1'b0;
    sample();
    chk("mr_rvalid_in_rst", {31'd0, cpu_rvalid}, 32'd0);

    next_cycle();
    rst = 1'b1;
    sample();
    chk("mr_rvalid_after", {31'd0, cpu_rvalid}, 32'd0);
    chk("mr_dma_rvalid_after", {31'd0, dma_rvalid}, 32'd0);
`ifdef DMEM_ARB_PERF_EN
    chk("mr_stall_cycles", cpu_stall_cycles, 32'd0);
`endif

    next_cycle();
    sample();
    chk("mr_rvalid_after2", {31'd0, cpu_rvalid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
